// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg
//   Shared definitions for the trap/return sequencer:
//   - CSR addresses touched by the sequence (mstatus, mtvec, mepc, mcause, mtval)
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - privilege encodings for the M/U-only core
//   - machine interrupt indices used by the priority encoder
//   - sequencer state encoding
//   - helper functions computing the mstatus update and the trap target
package trap_sequencer_pkg;

    // Width of the synchronous exception code presented by the pipeline.
    localparam int EXCEPTION_W = 4;

    // CSR addresses.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus bit positions.
    localparam int SR_MIE    = 3;
    localparam int SR_MPIE   = 7;
    localparam int SR_MPP_LO = 11;
    localparam int SR_MPP_HI = 12;

    // Privilege levels.
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Machine interrupt indices in mip/mie.
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_WR_EPC    = 3'd2,
        ST_WR_CAUSE  = 3'd3,
        ST_WR_TVAL   = 3'd4,
        ST_WR_STATUS = 3'd5,
        ST_RD_EPC    = 3'd6,
        ST_REDIRECT  = 3'd7
    } seq_state_t;

    // mstatus on trap entry: stash MIE in MPIE, disable interrupts, record
    // the privilege we came from in MPP.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] st,
                                                    input logic [1:0]  priv);
        logic [31:0] r;
        r                       = st;
        r[SR_MPIE]              = st[SR_MIE];
        r[SR_MIE]               = 1'b0;
        r[SR_MPP_HI:SR_MPP_LO]  = priv;
        return r;
    endfunction

    // mstatus on MRET: restore MIE from MPIE, set MPIE, drop MPP to U.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] st);
        logic [31:0] r;
        r                       = st;
        r[SR_MIE]               = st[SR_MPIE];
        r[SR_MPIE]              = 1'b1;
        r[SR_MPP_HI:SR_MPP_LO]  = PRIV_U;
        return r;
    endfunction

    // Privilege restored by MRET. Only M and U exist, so any MPP encoding
    // other than M collapses to U.
    function automatic logic [1:0] priv_after_mret(input logic [31:0] st);
        logic [1:0] r;
        if (st[SR_MPP_HI:SR_MPP_LO] == PRIV_M) begin
            r = PRIV_M;
        end else begin
            r = PRIV_U;
        end
        return r;
    endfunction

    // Trap handler address: mtvec base, or base + 4*idx for interrupts in
    // vectored mode (mtvec[1:0] == 1).
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic        is_irq,
                                                input logic [4:0]  idx,
                                                input logic        vec_en);
        logic [31:0] base;
        logic [31:0] r;
        base = {mtvec[31:2], 2'b00};
        if (vec_en && is_irq && (mtvec[1:0] == 2'b01)) begin
            r = base + {25'd0, idx, 2'b00};
        end else begin
            r = base;
        end
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_irq_prio.sv
// trap_irq_prio
//   Combinational priority encoder for pending machine interrupts.
//   Order: MEI(11), MSI(3), MTI(7); any other pending bit is resolved
//   lowest index first after those three.
// Ports:
//   pending_i [31:0]  mip & mie
//   any_o             at least one interrupt pending
//   idx_o [4:0]       index of the winning interrupt (0 when none)
module trap_irq_prio
    import trap_sequencer_pkg::*;
(
    input  logic [31:0] pending_i,
    output logic        any_o,
    output logic [4:0]  idx_o
);

    // Fixed-priority selection of the winning interrupt index.
    always_comb begin
        any_o = |pending_i;
        idx_o = 5'd0;
        if (pending_i[IRQ_MEI]) begin
            idx_o = IRQ_MEI;
        end else if (pending_i[IRQ_MSI]) begin
            idx_o = IRQ_MSI;
        end else if (pending_i[IRQ_MTI]) begin
            idx_o = IRQ_MTI;
        end else begin
            // Descending scan so the lowest set bit is the final assignment.
            for (int i = 31; i >= 0; i--) begin
                if (pending_i[i]) begin
                    idx_o = 5'(i);
                end else begin
                    idx_o = idx_o;
                end
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Multi-cycle trap / MRET controller between the pipeline and the CSR file.
//   Accepts exceptions, pending machine interrupts and MRET, drains the
//   pipeline, sequences the CSR side effects one access per cycle, updates
//   the privilege level and finishes with a one-cycle PC redirect.
// Parameters:
//   DRAIN_MAX    drain cycles before proceeding without pipe_empty_i
//   VECTORED_EN  honour vectored mtvec mode for interrupts
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   trap_valid_i/cause/pc/tval       exception request (held until ack)
//   mret_valid_i                     MRET request (held until ack)
//   irq_pending_i, irq_pc_i          mip & mie, PC of next unretired instr
//   mstatus_i                        current mstatus
//   pipe_empty_i                     no older instruction in flight
//   csr_rd_addr_o / csr_rd_data_i    CSR read port (combinational data)
//   csr_wr_en_o/addr_o/data_o        CSR write port
//   ack_o, flush_o                   acceptance pulse and pipeline flush
//   stall_o                          pipeline freeze during the sequence
//   redirect_valid_o/redirect_pc_o   fetch redirect
//   priv_o                           current privilege level
//   drain_timeout_o                  sticky drain-timeout flag
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int DRAIN_MAX   = 15,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trap_valid_i,
    input  logic [EXCEPTION_W-1:0] trap_cause_i,
    input  logic [31:0]            trap_pc_i,
    input  logic [31:0]            trap_tval_i,
    input  logic                   mret_valid_i,
    input  logic [31:0]            irq_pending_i,
    input  logic [31:0]            irq_pc_i,
    input  logic [31:0]            mstatus_i,
    input  logic                   pipe_empty_i,
    output logic [11:0]            csr_rd_addr_o,
    input  logic [31:0]            csr_rd_data_i,
    output logic                   csr_wr_en_o,
    output logic [11:0]            csr_wr_addr_o,
    output logic [31:0]            csr_wr_data_o,
    output logic                   ack_o,
    output logic                   flush_o,
    output logic                   stall_o,
    output logic                   redirect_valid_o,
    output logic [31:0]            redirect_pc_o,
    output logic [1:0]             priv_o,
    output logic                   drain_timeout_o
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q;

    // Latched request context.
    logic [31:0]      epc_q;
    logic [31:0]      cause_q;
    logic [31:0]      tval_q;
    logic [31:0]      mtvec_q;
    logic             is_irq_q;
    logic             is_mret_q;
    logic [4:0]       irq_idx_q;

    // Registered outputs.
    logic             ack_q;
    logic             stall_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic [1:0]       priv_q;
    logic             drain_timeout_q;

    logic             irq_any_s;
    logic [4:0]       irq_idx_s;
    logic             take_trap_s;
    logic             take_mret_s;
    logic             take_irq_s;
    logic             accept_s;
    logic             drain_ok_s;
    logic             drain_expired_s;
    logic [31:0]      target_s;

    trap_irq_prio u_irq_prio (
        .pending_i (irq_pending_i),
        .any_o     (irq_any_s),
        .idx_o     (irq_idx_s)
    );

    // Request arbitration in IDLE: exception > MRET > interrupt.
    always_comb begin
        take_trap_s = 1'b0;
        take_mret_s = 1'b0;
        take_irq_s  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (trap_valid_i) begin
                take_trap_s = 1'b1;
            end else if (mret_valid_i) begin
                take_mret_s = 1'b1;
            end else if (irq_any_s && (mstatus_i[SR_MIE] || (priv_q == PRIV_U))) begin
                take_irq_s = 1'b1;
            end else begin
                take_irq_s = 1'b0;
            end
        end else begin
            take_trap_s = 1'b0;
        end
        accept_s = take_trap_s | take_mret_s | take_irq_s;
    end

    // Drain exit conditions. Count 0 is the ack/flush cycle itself, so
    // pipe_empty_i is only trusted from the first real drain cycle on.
    always_comb begin
        drain_ok_s      = pipe_empty_i && (drain_cnt_q != {CNT_W{1'b0}});
        drain_expired_s = (drain_cnt_q == CNT_W'(DRAIN_MAX));
    end

    // Handler / return target, consumed when entering REDIRECT.
    always_comb begin
        if (is_mret_q) begin
            target_s = epc_q;
        end else begin
            target_s = trap_target(mtvec_q, is_irq_q, irq_idx_q, VECTORED_EN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s || drain_expired_s) begin
                    state_d = is_mret_q ? ST_RD_EPC : ST_WR_EPC;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WR_EPC:    state_d = ST_WR_CAUSE;
            ST_WR_CAUSE:  state_d = ST_WR_TVAL;
            ST_WR_TVAL:   state_d = ST_WR_STATUS;
            ST_WR_STATUS: state_d = ST_REDIRECT;
            ST_RD_EPC:    state_d = ST_WR_STATUS;
            ST_REDIRECT:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // CSR port decode: one access per state, address 0 when idle.
    always_comb begin
        csr_rd_addr_o = 12'h000;
        csr_wr_en_o   = 1'b0;
        csr_wr_addr_o = 12'h000;
        csr_wr_data_o = 32'h0000_0000;
        case (state_q)
            ST_WR_EPC: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MEPC;
                csr_wr_data_o = epc_q & 32'hFFFF_FFFC;
            end
            ST_WR_CAUSE: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MCAUSE;
                csr_wr_data_o = cause_q;
            end
            ST_WR_TVAL: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MTVAL;
                csr_wr_data_o = tval_q;
                csr_rd_addr_o = CSR_MTVEC;
            end
            ST_WR_STATUS: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = CSR_MSTATUS;
                if (is_mret_q) begin
                    csr_wr_data_o = mstatus_on_mret(mstatus_i);
                end else begin
                    csr_wr_data_o = mstatus_on_trap(mstatus_i, priv_q);
                end
            end
            ST_RD_EPC: begin
                csr_rd_addr_o = CSR_MEPC;
            end
            default: begin
                csr_wr_en_o = 1'b0;
            end
        endcase
    end

    // State, context latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            drain_cnt_q      <= {CNT_W{1'b0}};
            epc_q            <= 32'h0000_0000;
            cause_q          <= 32'h0000_0000;
            tval_q           <= 32'h0000_0000;
            mtvec_q          <= 32'h0000_0000;
            is_irq_q         <= 1'b0;
            is_mret_q        <= 1'b0;
            irq_idx_q        <= 5'd0;
            ack_q            <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
            priv_q           <= PRIV_M;
            drain_timeout_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            ack_q            <= accept_s;
            stall_q          <= (state_d != ST_IDLE);
            redirect_valid_q <= (state_d == ST_REDIRECT);

            if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
                drain_cnt_q <= drain_cnt_q + CNT_W'(1);
            end else begin
                drain_cnt_q <= {CNT_W{1'b0}};
            end

            // Sticky until reset: set only when the wait ran out, not when
            // the pipe emptied on the last allowed cycle.
            if ((state_q == ST_DRAIN) && drain_expired_s && !drain_ok_s) begin
                drain_timeout_q <= 1'b1;
            end

            if (take_trap_s) begin
                cause_q   <= {28'd0, trap_cause_i[3:0]};
                epc_q     <= trap_pc_i;
                tval_q    <= trap_tval_i;
                is_irq_q  <= 1'b0;
                is_mret_q <= 1'b0;
                irq_idx_q <= 5'd0;
            end else if (take_mret_s) begin
                is_irq_q  <= 1'b0;
                is_mret_q <= 1'b1;
                irq_idx_q <= 5'd0;
            end else if (take_irq_s) begin
                cause_q   <= {1'b1, 26'd0, irq_idx_s};
                epc_q     <= irq_pc_i;
                tval_q    <= 32'h0000_0000;
                is_irq_q  <= 1'b1;
                is_mret_q <= 1'b0;
                irq_idx_q <= irq_idx_s;
            end

            if (state_q == ST_WR_TVAL) begin
                mtvec_q <= csr_rd_data_i;
            end
            if (state_q == ST_RD_EPC) begin
                epc_q <= csr_rd_data_i;
            end

            if (state_q == ST_WR_STATUS) begin
                priv_q <= is_mret_q ? priv_after_mret(mstatus_i) : PRIV_M;
            end

            if (state_d == ST_REDIRECT) begin
                redirect_pc_q <= target_s;
            end
        end
    end

    assign ack_o            = ack_q;
    assign flush_o          = ack_q;
    assign stall_o          = stall_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign priv_o           = priv_q;
    assign drain_timeout_o  = drain_timeout_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   trap_valid_i;
    logic [EXCEPTION_W-1:0] trap_cause_i;
    logic [31:0]            trap_pc_i;
    logic [31:0]            trap_tval_i;
    logic                   mret_valid_i;
    logic [31:0]            irq_pending_i;
    logic [31:0]            irq_pc_i;
    logic [31:0]            mstatus_i;
    logic                   pipe_empty_i;
    logic [11:0]            csr_rd_addr_o;
    logic [31:0]            csr_rd_data_i;
    logic                   csr_wr_en_o;
    logic [11:0]            csr_wr_addr_o;
    logic [31:0]            csr_wr_data_o;
    logic                   ack_o;
    logic                   flush_o;
    logic                   stall_o;
    logic                   redirect_valid_o;
    logic [31:0]            redirect_pc_o;
    logic [1:0]             priv_o;
    logic                   drain_timeout_o;

    logic [31:0] mtvec_val;
    logic [31:0] mepc_val;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int red_n    = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .trap_valid_i     (trap_valid_i),
        .trap_cause_i     (trap_cause_i),
        .trap_pc_i        (trap_pc_i),
        .trap_tval_i      (trap_tval_i),
        .mret_valid_i     (mret_valid_i),
        .irq_pending_i    (irq_pending_i),
        .irq_pc_i         (irq_pc_i),
        .mstatus_i        (mstatus_i),
        .pipe_empty_i     (pipe_empty_i),
        .csr_rd_addr_o    (csr_rd_addr_o),
        .csr_rd_data_i    (csr_rd_data_i),
        .csr_wr_en_o      (csr_wr_en_o),
        .csr_wr_addr_o    (csr_wr_addr_o),
        .csr_wr_data_o    (csr_wr_data_o),
        .ack_o            (ack_o),
        .flush_o          (flush_o),
        .stall_o          (stall_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .priv_o           (priv_o),
        .drain_timeout_o  (drain_timeout_o)
    );

    // CSR file read stub: mtvec and mepc only.
    assign csr_rd_data_i = (csr_rd_addr_o == 12'h305) ? mtvec_val :
                           (csr_rd_addr_o == 12'h341) ? mepc_val  : 32'h0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Log CSR writes and redirects mid-cycle.
    always @(negedge clk) begin
        if (csr_wr_en_o === 1'b1) begin
            wa.push_back(csr_wr_addr_o);
            wd.push_back(csr_wr_data_o);
            wc.push_back(cyc);
        end
        if (redirect_valid_o === 1'b1) red_n <= red_n + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ack_o === 1'b1) begin
                c = cyc;
                break;
            end
        end
        n_checks++;
        if (c < 0) $display("FAIL ack_timeout: no ack in 40 cycles, expected an ack");
        else n_pass++;
    endtask

    task automatic wait_redirect(output int c, output logic [31:0] pc);
        c  = -1;
        pc = 32'h0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (redirect_valid_o === 1'b1) begin
                c  = cyc;
                pc = redirect_pc_o;
                break;
            end
        end
        n_checks++;
        if (c < 0) $display("FAIL redirect_timeout: no redirect in 60 cycles, expected one");
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (priv_o !== 2'b11 || redirect_pc_o !== 32'h0 || csr_wr_addr_o !== 12'h0 ||
            csr_wr_data_o !== 32'h0 || csr_rd_addr_o !== 12'h0)
            $display("FAIL reset_vectors: got priv %b pc %h wa %h wd %h ra %h, expected 11/0/0/0/0",
                     priv_o, redirect_pc_o, csr_wr_addr_o, csr_wr_data_o, csr_rd_addr_o);
        else n_pass++;
        n_checks++;
        if ({ack_o, flush_o, stall_o, redirect_valid_o, csr_wr_en_o, drain_timeout_o} !== 6'b0)
            $display("FAIL reset_bits: got %b, expected 000000",
                     {ack_o, flush_o, stall_o, redirect_valid_o, csr_wr_en_o, drain_timeout_o});
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_mret();
        int a, r, b;
        logic [31:0] pc;
        b         = wa.size();
        mepc_val  = 32'h0000_0400;
        mstatus_i = 32'h0000_0080;
        mret_valid_i = 1'b1;
        wait_ack(a);
        mret_valid_i = 1'b0;
        n_checks++;
        if (flush_o !== 1'b1 || stall_o !== 1'b1)
            $display("FAIL mret_ack_flags: got flush %b stall %b, expected 1 1", flush_o, stall_o);
        else n_pass++;
        wait_redirect(r, pc);
        n_checks++;
        if (r - a != 4 || pc !== 32'h0000_0400)
            $display("FAIL mret_redirect: got lat %0d pc %h, expected 4 00000400", r - a, pc);
        else n_pass++;
        n_checks++;
        if (priv_o !== 2'b00 || stall_o !== 1'b1)
            $display("FAIL mret_priv: got priv %b stall %b, expected 00 1", priv_o, stall_o);
        else n_pass++;
        n_checks++;
        if (wa.size() != b + 1)
            $display("FAIL mret_wr_count: got %0d, expected 1", wa.size() - b);
        else if (wa[b] !== 12'h300 || wd[b] !== 32'h0000_0088 || wc[b] != a + 3)
            $display("FAIL mret_status_wr: got addr %h data %h cyc %0d, expected 300 00000088 %0d",
                     wa[b], wd[b], wc[b], a + 3);
        else n_pass++;
        step();
        n_checks++;
        if (redirect_valid_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL mret_after: got redirect %b stall %b, expected 0 0", redirect_valid_o, stall_o);
        else n_pass++;
    endtask

    task automatic test_exception();
        int a, r, b;
        logic [31:0] pc;
        logic [11:0] exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{12'h341, 12'h342, 12'h343, 12'h300};
        exp_d = '{32'h0000_0100, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0080};
        b            = wa.size();
        mtvec_val    = 32'h8000_0001;
        mstatus_i    = 32'h0000_0008;
        trap_cause_i = 4'd2;
        trap_pc_i    = 32'h0000_0100;
        trap_tval_i  = 32'hDEAD_BEEF;
        trap_valid_i = 1'b1;
        wait_ack(a);
        trap_valid_i = 1'b0;
        wait_redirect(r, pc);
        n_checks++;
        if (r - a != 6 || pc !== 32'h8000_0000)
            $display("FAIL exc_redirect: got lat %0d pc %h, expected 6 80000000", r - a, pc);
        else n_pass++;
        n_checks++;
        if (priv_o !== 2'b11) $display("FAIL exc_priv: got %b, expected 11", priv_o);
        else n_pass++;
        n_checks++;
        if (wa.size() != b + 4) $display("FAIL exc_wr_count: got %0d, expected 4", wa.size() - b);
        else n_pass++;
        if (wa.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wa[b+i] !== exp_a[i] || wd[b+i] !== exp_d[i] || wc[b+i] != a + 2 + i)
                    $display("FAIL exc_wr%0d: got %h %h cyc %0d, expected %h %h cyc %0d",
                             i, wa[b+i], wd[b+i], wc[b+i], exp_a[i], exp_d[i], a + 2 + i);
                else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_irq();
        int a, r, b;
        logic [31:0] pc;
        logic [11:0] exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{12'h341, 12'h342, 12'h343, 12'h300};
        exp_d = '{32'h0000_0200, 32'h8000_0007, 32'h0000_0000, 32'h0000_1880};
        b             = wa.size();
        mstatus_i     = 32'h0000_0008;
        irq_pc_i      = 32'h0000_0200;
        irq_pending_i = 32'h0000_0080;
        wait_ack(a);
        irq_pending_i = 32'h0;
        wait_redirect(r, pc);
        n_checks++;
        if (r - a != 6 || pc !== 32'h8000_001C)
            $display("FAIL irq_redirect: got lat %0d pc %h, expected 6 8000001c", r - a, pc);
        else n_pass++;
        n_checks++;
        if (wa.size() != b + 4) $display("FAIL irq_wr_count: got %0d, expected 4", wa.size() - b);
        else n_pass++;
        if (wa.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wa[b+i] !== exp_a[i] || wd[b+i] !== exp_d[i])
                    $display("FAIL irq_wr%0d: got %h %h, expected %h %h",
                             i, wa[b+i], wd[b+i], exp_a[i], exp_d[i]);
                else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int a, r, a2, r2, b;
        logic [31:0] pc;
        b             = wa.size();
        mstatus_i     = 32'h0000_0008;
        trap_cause_i  = 4'd5;
        trap_pc_i     = 32'h0000_0300;
        trap_tval_i   = 32'h0000_1234;
        irq_pc_i      = 32'h0000_0500;
        irq_pending_i = 32'h0000_0880;
        trap_valid_i  = 1'b1;
        wait_ack(a);
        trap_valid_i  = 1'b0;
        wait_redirect(r, pc);
        n_checks++;
        if (r - a != 6 || pc !== 32'h8000_0000)
            $display("FAIL b2b_first_redirect: got lat %0d pc %h, expected 6 80000000", r - a, pc);
        else n_pass++;
        step();
        n_checks++;
        if (stall_o !== 1'b0 || ack_o !== 1'b0)
            $display("FAIL b2b_idle_gap: got stall %b ack %b, expected 0 0", stall_o, ack_o);
        else n_pass++;
        step();
        a2 = cyc;
        n_checks++;
        if (ack_o !== 1'b1) $display("FAIL b2b_second_ack: got %b, expected 1", ack_o);
        else n_pass++;
        irq_pending_i = 32'h0;
        wait_redirect(r2, pc);
        n_checks++;
        if (r2 - a2 != 6 || pc !== 32'h8000_002C)
            $display("FAIL b2b_irq_redirect: got lat %0d pc %h, expected 6 8000002c", r2 - a2, pc);
        else n_pass++;
        n_checks++;
        if (wa.size() != b + 8)
            $display("FAIL b2b_wr_count: got %0d, expected 8", wa.size() - b);
        else if (wd[b+1] !== 32'h0000_0005 || wd[b+4] !== 32'h0000_0500 || wd[b+5] !== 32'h8000_000B)
            $display("FAIL b2b_cause: got %h %h %h, expected 00000005 00000500 8000000b",
                     wd[b+1], wd[b+4], wd[b+5]);
        else n_pass++;
        step();
    endtask

    task automatic test_drain_timeout();
        int a, r;
        logic [31:0] pc;
        n_checks++;
        if (drain_timeout_o !== 1'b0) $display("FAIL dto_before: got %b, expected 0", drain_timeout_o);
        else n_pass++;
        pipe_empty_i = 1'b0;
        trap_cause_i = 4'd2;
        trap_pc_i    = 32'h0000_0106;
        trap_tval_i  = 32'h0;
        trap_valid_i = 1'b1;
        wait_ack(a);
        trap_valid_i = 1'b0;
        repeat (15) step();
        n_checks++;
        if (drain_timeout_o !== 1'b0 || csr_wr_en_o !== 1'b0)
            $display("FAIL dto_last_drain: got dto %b wr %b, expected 0 0", drain_timeout_o, csr_wr_en_o);
        else n_pass++;
        step();
        n_checks++;
        if (drain_timeout_o !== 1'b1 || csr_wr_en_o !== 1'b1 || csr_wr_addr_o !== 12'h341 ||
            csr_wr_data_o !== 32'h0000_0104)
            $display("FAIL dto_wr_epc: got dto %b wr %b %h %h, expected 1 1 341 00000104",
                     drain_timeout_o, csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o);
        else n_pass++;
        wait_redirect(r, pc);
        n_checks++;
        if (r - a != 20) $display("FAIL dto_latency: got %0d, expected 20", r - a);
        else n_pass++;
        pipe_empty_i = 1'b1;
        repeat (3) step();
        n_checks++;
        if (drain_timeout_o !== 1'b1) $display("FAIL dto_sticky: got %b, expected 1", drain_timeout_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int a, r, b, rn;
        logic [31:0] pc;
        mepc_val     = 32'h0000_0700;
        mstatus_i    = 32'h0000_0080;
        mret_valid_i = 1'b1;
        wait_ack(a);
        mret_valid_i = 1'b0;
        wait_redirect(r, pc);
        step();
        n_checks++;
        if (priv_o !== 2'b00) $display("FAIL rstmid_pre_priv: got %b, expected 00", priv_o);
        else n_pass++;
        b            = wa.size();
        rn           = red_n;
        trap_cause_i = 4'd3;
        trap_pc_i    = 32'h0000_0600;
        trap_tval_i  = 32'h0000_0055;
        trap_valid_i = 1'b1;
        wait_ack(a);
        trap_valid_i = 1'b0;
        repeat (3) step();
        n_checks++;
        if (csr_wr_addr_o !== 12'h342)
            $display("FAIL rstmid_in_cause: got %h, expected 342", csr_wr_addr_o);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (priv_o !== 2'b11 || stall_o !== 1'b0 || csr_wr_en_o !== 1'b0 || drain_timeout_o !== 1'b0)
            $display("FAIL rstmid_after: got priv %b stall %b wr %b dto %b, expected 11 0 0 0",
                     priv_o, stall_o, csr_wr_en_o, drain_timeout_o);
        else n_pass++;
        repeat (8) step();
        n_checks++;
        if (wa.size() != b + 2 || red_n != rn || priv_o !== 2'b11)
            $display("FAIL rstmid_no_effects: got writes %0d redirects %0d priv %b, expected 2 0 11",
                     wa.size() - b, red_n - rn, priv_o);
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        trap_valid_i  = 1'b0;
        trap_cause_i  = 4'd0;
        trap_pc_i     = 32'h0;
        trap_tval_i   = 32'h0;
        mret_valid_i  = 1'b0;
        irq_pending_i = 32'h0;
        irq_pc_i      = 32'h0;
        mstatus_i     = 32'h0;
        pipe_empty_i  = 1'b1;
        mtvec_val     = 32'h8000_0001;
        mepc_val      = 32'h0;
        test_reset();
        test_mret();
        test_exception();
        test_irq();
        test_back_to_back();
        test_drain_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
